// File: rtl/bpf_pktbuf_ctrl_pkg.sv
// Shared definitions for the BPF ping-pong packet buffer: per-buffer ownership states.
package bpf_pktbuf_ctrl_pkg;

  typedef logic [2:0] pbuf_state_t;

  localparam pbuf_state_t PBUF_FREE     = 3'd0;
  localparam pbuf_state_t PBUF_FILL     = 3'd1;
  localparam pbuf_state_t PBUF_READY    = 3'd2;
  localparam pbuf_state_t PBUF_WAIT_FWD = 3'd3;
  localparam pbuf_state_t PBUF_FWD      = 3'd4;

endpackage

// File: rtl/pktbuf_ram.sv
// Simple dual-port packet RAM: one write port, two independent registered read ports.
module pktbuf_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_a_en,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr,
  output logic [DATA_WIDTH-1:0] rd_a_data,
  input  logic                  rd_b_en,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr,
  output logic [DATA_WIDTH-1:0] rd_b_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output registers are reset; the array itself holds stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else begin
      if (rd_a_en) rd_a_data <= mem[rd_a_addr];
      if (rd_b_en) rd_b_data <= mem[rd_b_addr];
    end
  end

endmodule

// File: rtl/bpf_pktbuf_ctrl.sv
// Ping-pong packet buffer manager between snoop stream, BPF CPU and forwarder.
// Optional statistics counters are built when PKTBUF_STATS_EN is defined.
//
// state          | meaning
// PBUF_FREE      | empty, may accept a new packet
// PBUF_FILL      | snoop side writing packet words
// PBUF_READY     | packet complete, owned by the CPU for filtering
// PBUF_WAIT_FWD  | accepted, queued for the forwarder
// PBUF_FWD       | being read out by the forwarder
module bpf_pktbuf_ctrl
  import bpf_pktbuf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snoop_valid,
  input  logic [DATA_WIDTH-1:0] snoop_data,
  input  logic                  snoop_last,
  output logic                  mem_ready,
  input  logic                  cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic [ADDR_WIDTH+2:0] cpu_pkt_len,
  input  logic                  accept,
  input  logic                  reject,
  output logic                  fwd_pending,
  output logic [ADDR_WIDTH:0]   fwd_len,
  input  logic                  fwd_rd_en,
  input  logic [ADDR_WIDTH-1:0] fwd_rd_addr,
  output logic [DATA_WIDTH-1:0] fwd_rd_data,
  input  logic                  fwd_done
`ifdef PKTBUF_STATS_EN
  ,
  output logic [31:0]           stat_accepted,
  output logic [31:0]           stat_rejected,
  output logic [31:0]           stat_dropped
`endif
);

  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  pbuf_state_t             st_q  [2];
  pbuf_state_t             st_d  [2];
  logic [ADDR_WIDTH:0]     len_q [2];
  logic [ADDR_WIDTH:0]     len_d [2];
  logic                    fill_ptr_q, fill_ptr_d;
  logic                    cpu_ptr_q, cpu_ptr_d;
  logic                    in_pkt_q, in_pkt_d;
  logic                    dropping_q, dropping_d;
  logic [1:0]              wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    fwd_active, fwd_sel;
  logic                    cpu_sel_q, fwd_sel_q;
  logic [DATA_WIDTH-1:0]   ram_a_data [2];
  logic [DATA_WIDTH-1:0]   ram_b_data [2];

  assign fwd_active = (st_q[0] == PBUF_FWD) || (st_q[1] == PBUF_FWD);
  assign fwd_sel    = (st_q[1] == PBUF_FWD);

  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    fill_ptr_d = fill_ptr_q;
    cpu_ptr_d  = cpu_ptr_q;
    in_pkt_d   = in_pkt_q;
    dropping_d = dropping_q;
    wr_en      = '0;
    wr_addr    = '0;

    // Snoop side: a packet either fills buf[fill_ptr] or is dropped whole.
    if (snoop_valid) begin
      if (in_pkt_q) begin
        if (len_q[fill_ptr_q] != LEN_MAX) begin
          wr_en[fill_ptr_q]   = 1'b1;
          wr_addr             = len_q[fill_ptr_q][ADDR_WIDTH-1:0];
          len_d[fill_ptr_q]   = len_q[fill_ptr_q] + LEN_ONE;
        end
        if (snoop_last) begin
          st_d[fill_ptr_q] = PBUF_READY;
          fill_ptr_d       = ~fill_ptr_q;
          in_pkt_d         = 1'b0;
        end
      end else if (dropping_q) begin
        if (snoop_last) dropping_d = 1'b0;
      end else if (st_q[fill_ptr_q] == PBUF_FREE) begin
        wr_en[fill_ptr_q] = 1'b1;
        len_d[fill_ptr_q] = LEN_ONE;
        if (snoop_last) begin
          st_d[fill_ptr_q] = PBUF_READY;
          fill_ptr_d       = ~fill_ptr_q;
        end else begin
          st_d[fill_ptr_q] = PBUF_FILL;
          in_pkt_d         = 1'b1;
        end
      end else begin
        dropping_d = ~snoop_last;
      end
    end

    // CPU verdict; reject dominates a simultaneous accept.
    if (st_q[cpu_ptr_q] == PBUF_READY) begin
      if (reject) begin
        st_d[cpu_ptr_q] = PBUF_FREE;
        cpu_ptr_d       = ~cpu_ptr_q;
      end else if (accept) begin
        st_d[cpu_ptr_q] = PBUF_WAIT_FWD;
        cpu_ptr_d       = ~cpu_ptr_q;
      end
    end

    // With both queued, buf[cpu_ptr] was accepted first.
    if (fwd_active) begin
      if (fwd_done) st_d[fwd_sel] = PBUF_FREE;
    end else if (st_q[0] == PBUF_WAIT_FWD && st_q[1] == PBUF_WAIT_FWD) begin
      st_d[cpu_ptr_q] = PBUF_FWD;
    end else if (st_q[0] == PBUF_WAIT_FWD) begin
      st_d[0] = PBUF_FWD;
    end else if (st_q[1] == PBUF_WAIT_FWD) begin
      st_d[1] = PBUF_FWD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]    <= PBUF_FREE;
      st_q[1]    <= PBUF_FREE;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      fill_ptr_q <= 1'b0;
      cpu_ptr_q  <= 1'b0;
      in_pkt_q   <= 1'b0;
      dropping_q <= 1'b0;
      cpu_sel_q  <= 1'b0;
      fwd_sel_q  <= 1'b0;
    end else begin
      st_q[0]    <= st_d[0];
      st_q[1]    <= st_d[1];
      len_q[0]   <= len_d[0];
      len_q[1]   <= len_d[1];
      fill_ptr_q <= fill_ptr_d;
      cpu_ptr_q  <= cpu_ptr_d;
      in_pkt_q   <= in_pkt_d;
      dropping_q <= dropping_d;
      if (cpu_rd_en) cpu_sel_q <= cpu_ptr_q;
      if (fwd_rd_en && fwd_active) fwd_sel_q <= fwd_sel;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    pktbuf_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en[i]),
      .wr_addr   (wr_addr),
      .wr_data   (snoop_data),
      .rd_a_en   (cpu_rd_en && (cpu_ptr_q == 1'(i))),
      .rd_a_addr (cpu_rd_addr),
      .rd_a_data (ram_a_data[i]),
      .rd_b_en   (fwd_rd_en && fwd_active && (fwd_sel == 1'(i))),
      .rd_b_addr (fwd_rd_addr),
      .rd_b_data (ram_b_data[i])
    );
  end

  assign mem_ready   = (st_q[cpu_ptr_q] == PBUF_READY);
  assign cpu_pkt_len = {len_q[cpu_ptr_q], 2'b00};
  assign cpu_rd_data = ram_a_data[cpu_sel_q];
  assign fwd_pending = fwd_active;
  assign fwd_len     = len_q[fwd_sel];
  assign fwd_rd_data = ram_b_data[fwd_sel_q];

`ifdef PKTBUF_STATS_EN
  logic acc_evt, rej_evt, drop_evt;

  assign rej_evt  = reject && (st_q[cpu_ptr_q] == PBUF_READY);
  assign acc_evt  = accept && !reject && (st_q[cpu_ptr_q] == PBUF_READY);
  assign drop_evt = snoop_valid && !in_pkt_q && !dropping_q &&
                    (st_q[fill_ptr_q] != PBUF_FREE);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_rejected <= '0;
      stat_dropped  <= '0;
    end else begin
      if (acc_evt  && stat_accepted != 32'hFFFF_FFFF) stat_accepted <= stat_accepted + 32'd1;
      if (rej_evt  && stat_rejected != 32'hFFFF_FFFF) stat_rejected <= stat_rejected + 32'd1;
      if (drop_evt && stat_dropped  != 32'hFFFF_FFFF) stat_dropped  <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpf_pktbuf_ctrl.sv
// Directed bench for bpf_pktbuf_ctrl; forwarded packets are tracked in a scoreboard queue.
module tb_bpf_pktbuf_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          snoop_valid, snoop_last;
  logic [DW-1:0] snoop_data;
  logic          mem_ready;
  logic          cpu_rd_en;
  logic [AW-1:0] cpu_rd_addr;
  logic [DW-1:0] cpu_rd_data;
  logic [AW+2:0] cpu_pkt_len;
  logic          accept, reject;
  logic          fwd_pending;
  logic [AW:0]   fwd_len;
  logic          fwd_rd_en;
  logic [AW-1:0] fwd_rd_addr;
  logic [DW-1:0] fwd_rd_data;
  logic          fwd_done;
`ifdef PKTBUF_STATS_EN
  logic [31:0]   stat_accepted, stat_rejected, stat_dropped;
`endif

  int checks   = 0;
  int failures = 0;
  int          sb_len  [$];
  logic [31:0] sb_base [$];

  always #5 clk = ~clk;

  bpf_pktbuf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .snoop_valid (snoop_valid),
    .snoop_data  (snoop_data),
    .snoop_last  (snoop_last),
    .mem_ready   (mem_ready),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_rd_addr (cpu_rd_addr),
    .cpu_rd_data (cpu_rd_data),
    .cpu_pkt_len (cpu_pkt_len),
    .accept      (accept),
    .reject      (reject),
    .fwd_pending (fwd_pending),
    .fwd_len     (fwd_len),
    .fwd_rd_en   (fwd_rd_en),
    .fwd_rd_addr (fwd_rd_addr),
    .fwd_rd_data (fwd_rd_data),
    .fwd_done    (fwd_done)
`ifdef PKTBUF_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_rejected (stat_rejected),
    .stat_dropped  (stat_dropped)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      snoop_valid = 1'b1;
      snoop_data  = base + 32'(i);
      snoop_last  = (i == n - 1);
      tick();
    end
    snoop_valid = 1'b0;
    snoop_last  = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input int addr, input logic [31:0] exp);
    cpu_rd_en   = 1'b1;
    cpu_rd_addr = AW'(addr);
    tick();
    cpu_rd_en   = 1'b0;
    check(tag, 64'(cpu_rd_data), 64'(exp));
  endtask

  task automatic verdict(input logic acc, input logic rej, input int len, input logic [31:0] base);
    accept = acc;
    reject = rej;
    tick();
    accept = 1'b0;
    reject = 1'b0;
    if (acc && !rej) begin
      sb_len.push_back(len);
      sb_base.push_back(base);
    end
  endtask

  task automatic drain_fwd(input string tag);
    int n = 0;
    int len;
    logic [31:0] base;
    while (!fwd_pending && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_pending"}, 64'(fwd_pending), 64'd1);
    if (sb_len.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb_len.size()), 64'd1);
    end else begin
      len  = sb_len.pop_front();
      base = sb_base.pop_front();
      check({tag, "_len"}, 64'(fwd_len), 64'(len));
      fwd_rd_en   = 1'b1;
      fwd_rd_addr = AW'(len - 1);
      tick();
      fwd_rd_en   = 1'b0;
      check({tag, "_data"}, 64'(fwd_rd_data), 64'(base + 32'(len - 1)));
    end
    fwd_done = 1'b1;
    tick();
    fwd_done = 1'b0;
    check({tag, "_released"}, 64'(fwd_pending), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    snoop_valid = 1'b0; snoop_last = 1'b0; snoop_data = '0;
    cpu_rd_en = 1'b0; cpu_rd_addr = '0;
    accept = 1'b0; reject = 1'b0;
    fwd_rd_en = 1'b0; fwd_rd_addr = '0; fwd_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_fwd_pending", 64'(fwd_pending), 64'd0);
    check("rst_cpu_rd_data", 64'(cpu_rd_data), 64'd0);
    check("rst_fwd_rd_data", 64'(fwd_rd_data), 64'd0);
    check("rst_cpu_pkt_len", 64'(cpu_pkt_len), 64'd0);

    // 4-word packet, CPU read, accept and forward
    send_pkt(32'hA0, 4);
    check("p4_mem_ready", 64'(mem_ready), 64'd1);
    check("p4_pkt_len", 64'(cpu_pkt_len), 64'd16);
    cpu_read("p4_rd2", 2, 32'hA2);
    cpu_read("p4_rd0", 0, 32'hA0);
    verdict(1'b1, 1'b0, 4, 32'hA0);
    check("p4_mem_ready_low", 64'(mem_ready), 64'd0);
    drain_fwd("p4_fwd");

    // back-to-back 3 and 5 word packets, both accepted, forwarded oldest first
    send_pkt(32'hB0, 3);
    send_pkt(32'hC0, 5);
    check("b2b_len1", 64'(cpu_pkt_len), 64'd12);
    verdict(1'b1, 1'b0, 3, 32'hB0);
    check("b2b_ready2", 64'(mem_ready), 64'd1);
    check("b2b_len2", 64'(cpu_pkt_len), 64'd20);
    verdict(1'b1, 1'b0, 5, 32'hC0);
    check("b2b_idle", 64'(mem_ready), 64'd0);
    drain_fwd("b2b_fwd1");
    drain_fwd("b2b_fwd2");

    // three packets during CPU stall: the third is dropped
    send_pkt(32'hD0, 2);
    send_pkt(32'hE0, 2);
    send_pkt(32'hF0, 2);
`ifdef PKTBUF_STATS_EN
    check("drop_stat", 64'(stat_dropped), 64'd1);
`endif
    check("drop_len_d", 64'(cpu_pkt_len), 64'd8);
    cpu_read("drop_rd_d", 1, 32'hD1);
    verdict(1'b0, 1'b1, 0, 32'h0);
    check("drop_ready_e", 64'(mem_ready), 64'd1);
    cpu_read("drop_rd_e", 1, 32'hE1);
    send_pkt(32'h60, 3);
    verdict(1'b0, 1'b1, 0, 32'h0);
    check("fourth_ready", 64'(mem_ready), 64'd1);
    check("fourth_len", 64'(cpu_pkt_len), 64'd12);
    cpu_read("fourth_rd1", 1, 32'h61);
    verdict(1'b1, 1'b0, 3, 32'h60);
    drain_fwd("fourth_fwd");
`ifdef PKTBUF_STATS_EN
    check("stat_acc", 64'(stat_accepted), 64'd4);
    check("stat_rej", 64'(stat_rejected), 64'd2);
    check("stat_drop_final", 64'(stat_dropped), 64'd1);
`endif

    // overflow: 2**AW+3 words, length saturates and word 0 survives
    send_pkt(32'h1000, (1 << AW) + 3);
    check("ovf_ready", 64'(mem_ready), 64'd1);
    check("ovf_len", 64'(cpu_pkt_len), 64'((1 << AW) * 4));
    cpu_read("ovf_rd0", 0, 32'h1000);
    cpu_read("ovf_rd_last", (1 << AW) - 1, 32'h1000 + 32'((1 << AW) - 1));
    verdict(1'b0, 1'b1, 0, 32'h0);

    // simultaneous accept+reject: reject wins, nothing forwarded
    send_pkt(32'h77, 1);
    check("single_ready", 64'(mem_ready), 64'd1);
    check("single_len", 64'(cpu_pkt_len), 64'd4);
    verdict(1'b1, 1'b1, 0, 32'h0);
    check("ar_mem_ready", 64'(mem_ready), 64'd0);
    tick(); tick(); tick();
    check("ar_no_fwd", 64'(fwd_pending), 64'd0);

    // verdict with nothing ready is ignored
    verdict(1'b1, 1'b0, 0, 32'h0);
    void'(sb_len.pop_back());
    void'(sb_base.pop_back());
    tick(); tick(); tick();
    check("stray_accept", 64'(fwd_pending), 64'd0);

    // reset mid-fill
    snoop_valid = 1'b1; snoop_data = 32'h90; snoop_last = 1'b0;
    tick();
    snoop_data = 32'h91;
    tick();
    snoop_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_mem_ready", 64'(mem_ready), 64'd0);
    check("midrst_fwd_pending", 64'(fwd_pending), 64'd0);
`ifdef PKTBUF_STATS_EN
    check("midrst_stat_acc", 64'(stat_accepted), 64'd0);
`endif
    send_pkt(32'h50, 2);
    check("postrst_ready", 64'(mem_ready), 64'd1);
    check("postrst_len", 64'(cpu_pkt_len), 64'd8);
    cpu_read("postrst_rd0", 0, 32'h50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpf_pktbuf_ctrl.md
Name: bpf_pktbuf_ctrl

Overview:
Ping-pong packet buffer manager that feeds the BPF CPU controller and consumes its verdict. It holds two packet buffers:
- A snoop-side stream fills one buffer while the CPU filters the other.
- `mem_ready` tells the CPU a packet is loaded.
- An `accept` pulse queues the buffer for the forwarder; a `reject` pulse frees it.
- Contains the buffer RAMs and a three-way ownership FSM (snoop / CPU / forwarder) per buffer.

Parameters:
- ADDR_WIDTH, 9, word-address width per buffer; buffer depth = 2**ADDR_WIDTH 32-bit words.
- DATA_WIDTH, 32, RAM word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- snoop_valid  in  1  incoming packet word valid (no backpressure).
- snoop_data  in  DATA_WIDTH  packet word.
- snoop_last  in  1  final word of packet.
- mem_ready  out  1  packet ready for CPU (to controller).
- cpu_rd_en  in  1  CPU packet read strobe.
- cpu_rd_addr  in  ADDR_WIDTH  CPU word address.
- cpu_rd_data  out  DATA_WIDTH  read data, 1-cycle latency.
- cpu_pkt_len  out  ADDR_WIDTH+3  byte length of CPU packet (words*4).
- accept  in  1  verdict pulse from controller.
- reject  in  1  verdict pulse from controller.
- fwd_pending  out  1  a packet awaits/is in forwarding.
- fwd_len  out  ADDR_WIDTH+1  word count of forwarded packet.
- fwd_rd_en  in  1  forwarder read strobe.
- fwd_rd_addr  in  ADDR_WIDTH  forwarder word address.
- fwd_rd_data  out  DATA_WIDTH  read data, 1-cycle latency.
- fwd_done  in  1  forwarder finished; releases buffer.

Behaviour:
- Per-buffer state: FREE → FILL → READY → (WAIT_FWD → FWD → FREE) | FREE.
- Pointers `fill_ptr` and `cpu_ptr` (1 bit each) toggle after each use. Reset: both buffers FREE, pointers 0, all counters 0, `mem_ready` = 0, `fwd_pending` = 0, read data 0.

Snoop side:
- First `snoop_valid` of a packet with `buf[fill_ptr]` FREE: the buffer goes FILL, and the word is written at address 0. Words are written sequentially; `len` counts words.
- Otherwise the packet is dropped: all words through `snoop_last` are ignored and `fill_ptr` is unchanged.
- Overflow: words beyond depth are discarded and `len` saturates at 2**ADDR_WIDTH.
- On `snoop_last`: the buffer goes READY and `fill_ptr` toggles.
- A single-word packet (`valid` and `last` on the first word) goes FREE→READY in one cycle.

CPU side:
- `mem_ready` = (`buf[cpu_ptr]` == READY), combinational from registered state.
- `cpu_rd_*` address `buf[cpu_ptr]`.
- `accept` (while READY): buffer → WAIT_FWD, `cpu_ptr` toggles.
- `reject` (while READY): buffer → FREE, `cpu_ptr` toggles.
- `accept` and `reject` together: reject wins.
- Verdict pulse while not READY: ignored.
- `mem_ready` is visible low no later than the cycle after the verdict, so the controller's reset state does not restart on a stale packet.

Forwarder side:
- If any buffer is FWD, it is the forwarder buffer.
- Else if exactly one buffer is WAIT_FWD, it becomes FWD.
- If both are WAIT_FWD, `buf[cpu_ptr]` (the older) becomes FWD.
- `fwd_pending` = any buffer in FWD; `fwd_len` is that buffer's `len`.
- `fwd_done` while FWD → FREE. `fwd_done` otherwise is ignored.

Simultaneous events:
- All state changes take effect at the next edge.
- A packet start in the same cycle as `fwd_done`/`reject` freeing `buf[fill_ptr]` sees non-FREE and drops.
- Reset mid-packet: the next `snoop_valid` is treated as a packet start (upstream re-syncs).

Read ports:
- Independent CPU and forwarder read ports.
- A read of an address ≥ `len` returns stale RAM contents (no check).

Optional Feature:
- Macro `PKTBUF_STATS_EN`.
- Defined: adds outputs `stat_accepted`, `stat_rejected`, `stat_dropped` (32-bit each), counting accept, reject and dropped-packet events.
  - Counters are cleared by rst and saturate at 0xFFFFFFFF.
  - A dropped packet is counted once, at its first word.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header `bpf_defs.vh`: buffer state encodings (`PBUF_FREE`, `PBUF_FILL`, `PBUF_READY`, `PBUF_WAIT_FWD`, `PBUF_FWD`).
- Sub-module `pktbuf_ram`: one simple-dual-port RAM, 1 write / 2 read ports, 1-cycle registered read. Instantiated twice.
- Top-level holds the FSMs, pointers and output muxes.

Test Plan:
- 4-word packet 0xA0..0xA3 → `mem_ready` high the cycle after last; `cpu_pkt_len` = 16; `cpu_rd_addr` 2 returns 0xA2 next cycle.
- `accept` → `mem_ready` low next cycle; `fwd_pending` = 1, `fwd_len` = 4; `fwd_done` → buffer FREE, `fwd_pending` = 0.
- Two back-to-back packets (3 words, 5 words); CPU accepts both, forwarder idle → packet 1 (len 3) forwarded first, then len 5.
- Three packets arrive while CPU stalls → third packet dropped; `stat_dropped` = 1 (with `PKTBUF_STATS_EN`); subsequent `reject` frees buffer and the fourth packet is accepted into it.
- Packet of 2**ADDR_WIDTH+3 words → `len` saturates at 512; word 512 not written over word 0.
- `accept`+`reject` same cycle → buffer FREE, `fwd_pending` stays 0; rst asserted mid-fill → all buffers FREE, `mem_ready` = 0 next cycle.
